// File: rtl/neuro_spider.sv
// rtl/neuro_spider.sv - single-neuron fp16 multiply-accumulate accelerator with host port
`timescale 1ns/1ps
module neuro_spider #(
   parameter int AW      = 8,
   parameter int MUL_LAT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        StartOperation,
   input  logic        WE,
   input  logic [15:0] Address,
   input  logic [15:0] DataWrite,
   output logic        ReadyNextOperation,
   output logic [15:0] DataRead
);
   localparam int          DEPTH   = 1 << AW;
   localparam logic [15:0] FP_QNAN = 16'h7E00;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH_IDX, S_FETCH_OPS, S_MUL, S_ADD, S_FINISH
   } state_t;

   state_t state_q, state_d;

   logic [15:0] in_off_q, dest_q, num_ops_q, cache_sel_q, ctrl_q, idx_off_q, w_off_q;
   logic [15:0] l1_q [DEPTH];
   logic [15:0] i0_q [DEPTH];
   logic [15:0] w0_q [DEPTH];
   logic [15:0] o_q  [DEPTH];

   logic [15:0]   acc_q, a_q, b_q, prod_q, k_q;
   logic [AW-1:0] ix_q;
   logic [7:0]    mul_cnt_q;

   logic          ready, o_we, host_we, mul_last, last_op;
   logic [15:0]   fin_value, reg_rd, cache_rd, rd_d;
   logic [AW-1:0] idx_addr, in_addr, w_addr, host_addr;

   // Truncating multiply; subnormals count as zero, Inf*0 is invalid.
   function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
      logic        sgn, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
      logic [21:0] p;
      logic [15:0] r;
      int          e;
      sgn    = a[15] ^ b[15];
      nan_a  = (&a[14:10]) && (|a[9:0]);
      nan_b  = (&b[14:10]) && (|b[9:0]);
      inf_a  = (&a[14:10]) && !(|a[9:0]);
      inf_b  = (&b[14:10]) && !(|b[9:0]);
      zero_a = (a[14:10] == 5'd0);
      zero_b = (b[14:10] == 5'd0);
      p = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
      e = int'(a[14:10]) + int'(b[14:10]) - 15 + int'(p[21]);
      if (nan_a || nan_b)                        r = FP_QNAN;
      else if ((inf_a && zero_b) || (inf_b && zero_a)) r = FP_QNAN;
      else if (inf_a || inf_b)                   r = {sgn, 5'h1F, 10'h000};
      else if (zero_a || zero_b)                 r = {sgn, 15'h0000};
      else if (e >= 31)                          r = {sgn, 5'h1F, 10'h000};
      else if (e <= 0)                           r = {sgn, 15'h0000};
      else                                       r = {sgn, 5'(e), 10'(p >> (p[21] ? 11 : 10))};
      return r;
   endfunction

   // Exact wide alignment so truncation sees the full difference.
   function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
      logic        sgn, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
      logic [15:0] big, sml, r;
      logic [40:0] mb, ms, s, n;
      int          d, p, e;
      nan_a  = (&a[14:10]) && (|a[9:0]);
      nan_b  = (&b[14:10]) && (|b[9:0]);
      inf_a  = (&a[14:10]) && !(|a[9:0]);
      inf_b  = (&b[14:10]) && !(|b[9:0]);
      zero_a = (a[14:10] == 5'd0);
      zero_b = (b[14:10] == 5'd0);
      if (a[14:10] >= b[14:10]) begin
         big = a;
         sml = b;
      end else begin
         big = b;
         sml = a;
      end
      d  = int'(big[14:10]) - int'(sml[14:10]);
      mb = {30'd0, 1'b1, big[9:0]} << d;
      ms = {30'd0, 1'b1, sml[9:0]};
      if (big[15] == sml[15]) begin
         s   = mb + ms;
         sgn = big[15];
      end else if (mb >= ms) begin
         s   = mb - ms;
         sgn = big[15];
      end else begin
         s   = ms - mb;
         sgn = sml[15];
      end
      p = 0;
      for (int i = 0; i < 41; i++) if (s[i]) p = i;
      e = p + int'(sml[14:10]) - 10;
      n = s << (40 - p);
      if (nan_a || nan_b)                           r = FP_QNAN;
      else if (inf_a && inf_b && (a[15] != b[15]))  r = FP_QNAN;
      else if (inf_a)                               r = a;
      else if (inf_b)                               r = b;
      else if (zero_a && zero_b)                    r = 16'h0000;
      else if (zero_a)                              r = b;
      else if (zero_b)                              r = a;
      else if (s == 41'd0)                          r = 16'h0000;
      else if (e >= 31)                             r = {sgn, 5'h1F, 10'h000};
      else if (e <= 0)                              r = {sgn, 15'h0000};
      else                                          r = {sgn, 5'(e), 10'(n >> 30)};
      return r;
   endfunction

   assign idx_addr  = idx_off_q[AW-1:0] + k_q[AW-1:0];
   assign w_addr    = w_off_q[AW-1:0] + k_q[AW-1:0];
   assign in_addr   = in_off_q[AW-1:0] - AW'(1) + ix_q;
   assign host_addr = Address[AW-1:0];
   assign mul_last  = (mul_cnt_q == 8'(MUL_LAT - 1));
   assign last_op   = ((k_q + 16'd1) == num_ops_q);
   assign fin_value = (ctrl_q[5] && acc_q[15]) ? 16'h0000 : acc_q;
   assign host_we   = ready && WE;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:      if (StartOperation) state_d = (num_ops_q == 16'd0) ? S_FINISH : S_FETCH_IDX;
         S_FETCH_IDX: state_d = S_FETCH_OPS;
         S_FETCH_OPS: state_d = S_MUL;
         S_MUL:       if (mul_last) state_d = S_ADD;
         S_ADD:       state_d = last_op ? S_FINISH : S_FETCH_IDX;
         S_FINISH:    state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ready = 1'b0;
      o_we  = 1'b0;
      case (state_q)
         S_IDLE:   ready = 1'b1;
         S_FINISH: o_we  = 1'b1;
         default:  ;
      endcase
   end

   assign ReadyNextOperation = ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_off_q    <= '0;
         dest_q      <= '0;
         num_ops_q   <= '0;
         cache_sel_q <= '0;
         ctrl_q      <= '0;
         idx_off_q   <= '0;
         w_off_q     <= '0;
      end else if (host_we && Address[15]) begin
         case (Address[14:0])
            15'd0:   in_off_q    <= DataWrite;
            15'd1:   dest_q      <= DataWrite;
            15'd2:   num_ops_q   <= DataWrite;
            15'd3:   cache_sel_q <= DataWrite;
            15'd4:   ctrl_q      <= DataWrite;
            15'd5:   idx_off_q   <= DataWrite;
            15'd6:   w_off_q     <= DataWrite;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         prod_q    <= '0;
         k_q       <= '0;
         ix_q      <= '0;
         mul_cnt_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (StartOperation) begin
               acc_q <= 16'h0000;
               k_q   <= 16'd0;
            end
            S_FETCH_IDX: ix_q <= i0_q[idx_addr][AW-1:0];
            S_FETCH_OPS: begin
               a_q       <= l1_q[in_addr];
               b_q       <= w0_q[w_addr];
               mul_cnt_q <= 8'd0;
            end
            S_MUL: begin
               mul_cnt_q <= mul_cnt_q + 8'd1;
               if (mul_last) prod_q <= fp16_mul(a_q, b_q);
            end
            S_ADD: begin
               acc_q <= fp16_add(acc_q, prod_q);
               k_q   <= k_q + 16'd1;
            end
            default: ;
         endcase
      end
   end

   // Cache storage has no reset; a reset mid-run leaves state IDLE so O is never written.
   always_ff @(posedge clk) begin
      if (host_we && !Address[15]) begin
         case (cache_sel_q)
            16'd0:   l1_q[host_addr] <= DataWrite;
            16'd1:   i0_q[host_addr] <= DataWrite;
            16'd3:   w0_q[host_addr] <= DataWrite;
            16'd4:   o_q[host_addr]  <= DataWrite;
            default: ;
         endcase
      end
      if (o_we) o_q[dest_q[AW-1:0]] <= fin_value;
   end

   always_comb begin
      reg_rd = 16'h0000;
      case (Address[14:0])
         15'd0:   reg_rd = in_off_q;
         15'd1:   reg_rd = dest_q;
         15'd2:   reg_rd = num_ops_q;
         15'd3:   reg_rd = cache_sel_q;
         15'd4:   reg_rd = ctrl_q;
         15'd5:   reg_rd = idx_off_q;
         15'd6:   reg_rd = w_off_q;
         default: reg_rd = 16'h0000;
      endcase
   end

   always_comb begin
      cache_rd = 16'h0000;
      case (cache_sel_q)
         16'd0:   cache_rd = l1_q[host_addr];
         16'd1:   cache_rd = i0_q[host_addr];
         16'd3:   cache_rd = w0_q[host_addr];
         16'd4:   cache_rd = o_q[host_addr];
         default: cache_rd = 16'h0000;
      endcase
   end

   assign rd_d = Address[15] ? reg_rd : cache_rd;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) DataRead <= 16'h0000;
      else       DataRead <= rd_d;
   end

endmodule

// File: tb/tb_neuro_spider.sv
// tb/tb_neuro_spider.sv - directed and randomized checks of neuro_spider against an exact-arithmetic fp16 model
`timescale 1ns/1ps
module tb_neuro_spider;
   logic        clk = 1'b0;
   logic        reset, StartOperation, WE, Ready;
   logic [15:0] Address, DataWrite, DataRead;
   int          n_checks = 0;
   int          n_fail   = 0;

   neuro_spider #(.AW(8), .MUL_LAT(2)) dut (
      .clk(clk), .reset(reset), .StartOperation(StartOperation), .WE(WE),
      .Address(Address), .DataWrite(DataWrite),
      .ReadyNextOperation(Ready), .DataRead(DataRead)
   );

   always #5 clk = ~clk;

   logic [15:0] m_l1 [256];
   logic [15:0] m_i0 [256];
   logic [15:0] m_w0 [256];
   logic [15:0] m_o  [256];
   logic [15:0] m_reg [7];

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Values as exact integers: magnitude * 2^scale, packed with truncation.
   function automatic logic [15:0] fp_pack(input bit sgn, input longint unsigned mag, input int scale);
      int p = 0;
      int be;
      longint unsigned man;
      for (int i = 0; i < 64; i++) if (mag[i]) p = i;
      be = p + scale + 15;
      if (be >= 31) return {sgn, 5'h1F, 10'h000};
      if (be <= 0)  return {sgn, 15'h0000};
      man = (p >= 10) ? (mag >> (p - 10)) : (mag << (10 - p));
      return {sgn, 5'(be), 10'(man)};
   endfunction

   function automatic bit is_nan(input logic [15:0] x);
      return (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
   endfunction
   function automatic bit is_inf(input logic [15:0] x);
      return (x[14:10] == 5'h1F) && (x[9:0] == 10'd0);
   endfunction
   function automatic bit is_zero(input logic [15:0] x);
      return x[14:10] == 5'd0;
   endfunction

   function automatic logic [15:0] m_mul(input logic [15:0] a, input logic [15:0] b);
      bit sgn = a[15] ^ b[15];
      longint unsigned ma, mb;
      if (is_nan(a) || is_nan(b)) return 16'h7E00;
      if ((is_inf(a) && is_zero(b)) || (is_inf(b) && is_zero(a))) return 16'h7E00;
      if (is_inf(a) || is_inf(b)) return {sgn, 5'h1F, 10'h000};
      if (is_zero(a) || is_zero(b)) return {sgn, 15'h0000};
      ma = 64'd1024 + 64'(a[9:0]);
      mb = 64'd1024 + 64'(b[9:0]);
      return fp_pack(sgn, ma * mb, int'(a[14:10]) + int'(b[14:10]) - 50);
   endfunction

   // Signed value in units of 2^-24; every fp16 normal is an exact multiple.
   function automatic longint to_units(input logic [15:0] x);
      longint m;
      if (is_zero(x)) return 0;
      m = longint'(1024 + int'(x[9:0])) <<< (int'(x[14:10]) - 1);
      return x[15] ? -m : m;
   endfunction

   function automatic logic [15:0] m_add(input logic [15:0] a, input logic [15:0] b);
      longint s;
      if (is_nan(a) || is_nan(b)) return 16'h7E00;
      if (is_inf(a) && is_inf(b) && (a[15] != b[15])) return 16'h7E00;
      if (is_inf(a)) return a;
      if (is_inf(b)) return b;
      s = to_units(a) + to_units(b);
      if (s == 0) return 16'h0000;
      if (s < 0) return fp_pack(1'b1, longint'(-s), -24);
      return fp_pack(1'b0, s, -24);
   endfunction

   function automatic logic [15:0] model_neuron();
      logic [15:0] acc, a, b;
      int ix;
      acc = 16'h0000;
      for (int k = 0; k < int'(m_reg[2]); k++) begin
         ix  = int'(m_i0[(int'(m_reg[5]) + k) & 255]);
         a   = m_l1[(int'(m_reg[0]) - 1 + ix) & 255];
         b   = m_w0[(int'(m_reg[6]) + k) & 255];
         acc = m_add(acc, m_mul(a, b));
      end
      if (m_reg[4][5] && acc[15]) acc = 16'h0000;
      return acc;
   endfunction

   function automatic logic [15:0] rand_fp();
      int r = $urandom_range(0, 59);
      if (r == 0) return 16'h7C00;
      if (r == 1) return 16'hFC00;
      if (r == 2) return 16'h7E55;
      if (r == 3) return 16'h0123;
      if (r == 4) return 16'h8000;
      if (r == 5) return {1'($urandom_range(0, 1)), 5'($urandom_range(1, 30)), 10'($urandom)};
      return {1'($urandom_range(0, 1)), 5'($urandom_range(8, 22)), 10'($urandom)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic host_wr(input logic [15:0] addr, input logic [15:0] data);
      Address = addr; DataWrite = data; WE = 1'b1;
      tick();
      WE = 1'b0;
   endtask

   task automatic host_rd(input logic [15:0] addr, output logic [15:0] data);
      Address = addr; WE = 1'b0;
      tick();
      data = DataRead;
   endtask

   task automatic wr_reg(input int idx, input logic [15:0] v);
      host_wr(16'h8000 + 16'(idx), v);
      m_reg[idx] = v;
   endtask

   task automatic wr_cache(input int sel, input int addr, input logic [15:0] v);
      if (m_reg[3] != 16'(sel)) wr_reg(3, 16'(sel));
      host_wr(16'(addr & 255), v);
      case (sel)
         0: m_l1[addr & 255] = v;
         1: m_i0[addr & 255] = v;
         3: m_w0[addr & 255] = v;
         4: m_o[addr & 255]  = v;
         default: ;
      endcase
   endtask

   task automatic rd_cache(input int sel, input int addr, output logic [15:0] v);
      if (m_reg[3] != 16'(sel)) wr_reg(3, 16'(sel));
      host_rd(16'(addr & 255), v);
   endtask

   task automatic wait_ready(input string tag, input int bound, input int start_cyc);
      int cyc = start_cyc;
      while (Ready !== 1'b1 && cyc < bound + 20) begin
         tick();
         cyc++;
      end
      check({tag, "/latency"}, {15'd0, cyc <= bound}, 16'd1);
   endtask

   task automatic run_op(input string tag, output logic [15:0] got, output logic [15:0] expv);
      int n = int'(m_reg[2]);
      expv = model_neuron();
      StartOperation = 1'b1;
      tick();
      StartOperation = 1'b0;
      check({tag, "/busy"}, {15'd0, Ready}, 16'd0);
      wait_ready(tag, (n == 0) ? 3 : 8 + 6 * n, 1);
      m_o[m_reg[1][7:0]] = expv;
      rd_cache(4, int'(m_reg[1][7:0]), got);
      check(tag, got, expv);
   endtask

   task automatic setup_random(input int n, input int dest, input bit relu);
      int ix;
      wr_reg(0, 16'($urandom));
      wr_reg(5, 16'($urandom));
      wr_reg(6, 16'($urandom));
      wr_reg(1, 16'(dest));
      wr_reg(2, 16'(n));
      wr_reg(4, (16'($urandom) & ~16'h0020) | (relu ? 16'h0020 : 16'h0000));
      for (int k = 0; k < n; k++) wr_cache(1, int'(m_reg[5]) + k, 16'($urandom));
      for (int k = 0; k < n; k++) begin
         ix = int'(m_i0[(int'(m_reg[5]) + k) & 255]);
         wr_cache(0, int'(m_reg[0]) - 1 + ix, rand_fp());
      end
      for (int k = 0; k < n; k++) wr_cache(3, int'(m_reg[6]) + k, rand_fp());
   endtask

   task automatic setup_single(input logic [15:0] a, input logic [15:0] b);
      wr_reg(0, 16'd1); wr_reg(5, 16'd1); wr_reg(6, 16'd1);
      wr_reg(1, 16'd2); wr_reg(2, 16'd1); wr_reg(4, 16'd0);
      wr_cache(1, 1, 16'd1);
      wr_cache(0, 1, a);
      wr_cache(3, 1, b);
   endtask

   logic [15:0] v, expv, old_w;
   logic [15:0] tbl [8][3];

   initial begin
      reset = 1'b1; StartOperation = 1'b0; WE = 1'b0; Address = '0; DataWrite = '0;
      for (int i = 0; i < 7; i++) m_reg[i] = 16'h0000;
      repeat (2) @(posedge clk);
      #1;
      check("reset/ready", {15'd0, Ready}, 16'd1);
      check("reset/dataread", DataRead, 16'h0000);
      reset = 1'b0;
      tick();
      host_rd(16'h8004, v);
      check("reset/ctrl", v, 16'h0000);

      wr_reg(0, 16'd1); wr_reg(5, 16'd1); wr_reg(6, 16'd1);
      wr_reg(1, 16'd1); wr_reg(2, 16'd2); wr_reg(4, 16'd0);
      wr_cache(0, 1, 16'h3C00); wr_cache(0, 2, 16'h4000);
      wr_cache(1, 1, 16'd1);    wr_cache(1, 2, 16'd2);
      wr_cache(3, 1, 16'h3C00); wr_cache(3, 2, 16'h4000);
      run_op("dot_pos", v, expv);
      check("dot_pos/const", v, 16'h4500);
      wr_cache(3, 2, 16'hC000);
      run_op("dot_neg", v, expv);
      check("dot_neg/const", v, 16'hC200);
      wr_reg(4, 16'h0060);
      run_op("dot_relu", v, expv);
      check("dot_relu/const", v, 16'h0000);

      wr_reg(2, 16'h0002);
      host_rd(16'h8002, v);
      check("reg/numops", v, 16'h0002);
      host_rd(16'h8004, v);
      check("reg/ctrl", v, 16'h0060);
      host_rd(16'h8007, v);
      check("reg/unmapped", v, 16'h0000);

      wr_cache(4, 3, 16'h5555);
      wr_reg(1, 16'd3); wr_reg(2, 16'd0);
      run_op("numops0", v, expv);
      check("numops0/const", v, 16'h0000);

      tbl[0] = '{16'h7BFF, 16'h7BFF, 16'h7C00};
      tbl[1] = '{16'hFBFF, 16'h7BFF, 16'hFC00};
      tbl[2] = '{16'h0400, 16'h0400, 16'h0000};
      tbl[3] = '{16'h7E00, 16'h3C00, 16'h7E00};
      tbl[4] = '{16'h7C00, 16'h0000, 16'h7E00};
      tbl[5] = '{16'h0001, 16'h3C00, 16'h0000};
      tbl[6] = '{16'h3C00, 16'hC000, 16'hC000};
      tbl[7] = '{16'h3E00, 16'h3E00, 16'h4080};
      for (int i = 0; i < 8; i++) begin
         setup_single(tbl[i][0], tbl[i][1]);
         run_op($sformatf("edge%0d", i), v, expv);
         check($sformatf("edge%0d/const", i), v, tbl[i][2]);
      end

      // Host start/write attempts during a run must be dropped.
      setup_random(4, 7, 1'b0);
      wr_reg(3, 16'd3);
      expv  = model_neuron();
      old_w = m_w0[m_reg[6][7:0]];
      StartOperation = 1'b1;
      tick();
      StartOperation = 1'b0;
      tick();
      StartOperation = 1'b1;
      tick();
      StartOperation = 1'b0;
      Address = {8'd0, m_reg[6][7:0]}; DataWrite = ~old_w; WE = 1'b1;
      tick();
      Address = 16'h8002; DataWrite = 16'd9;
      tick();
      WE = 1'b0;
      wait_ready("busy", 8 + 6 * 4, 5);
      m_o[7] = expv;
      rd_cache(4, 7, v);
      check("busy/result", v, expv);
      rd_cache(3, int'(m_reg[6][7:0]), v);
      check("busy/w0_kept", v, old_w);
      host_rd(16'h8002, v);
      check("busy/numops_kept", v, 16'd4);

      for (int it = 0; it < 30; it++) begin
         setup_random($urandom_range(1, 12), $urandom_range(0, 255), 1'($urandom_range(0, 1)));
         run_op($sformatf("rand%0d", it), v, expv);
      end

      wr_cache(4, 5, 16'h1357);
      setup_random(6, 5, 1'b0);
      StartOperation = 1'b1;
      tick();
      StartOperation = 1'b0;
      repeat (5) tick();
      #2 reset = 1'b1;
      #1;
      check("abort/ready", {15'd0, Ready}, 16'd1);
      check("abort/dataread", DataRead, 16'h0000);
      @(posedge clk);
      #1 reset = 1'b0;
      for (int i = 0; i < 7; i++) m_reg[i] = 16'h0000;
      host_rd(16'h8002, v);
      check("abort/numops", v, 16'h0000);
      host_rd(16'h8001, v);
      check("abort/dest", v, 16'h0000);
      rd_cache(4, 5, v);
      check("abort/o_kept", v, 16'h1357);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
